qif_spike_receiver: RTL and testbench

Receive end of the QIF neuron spike link: consumes the 1-bit spike train from an upstream neuron and decodes it into three quantities.
- A decaying signed 8-bit synaptic current, suitable for driving a downstream neuron's signed 8-bit input.
- A measured inter-spike interval (ISI) in clock cycles.
- A windowed spike-rate count.

It sits between neuron instances in a chain and forms the decoder half of the spike encoding the neuron performs.

---
 rtl/qif_spike_receiver.sv | 150 +++++++++++++++
 tb/tb_qif_spike_receiver.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qif_spike_receiver.sv
// QIF spike-link receiver: decodes a spike train into a decaying synaptic current, an inter-spike interval and a windowed rate.
// Optional rate window logic is compiled in when QIF_RX_RATE_EN is defined.
module qif_spike_receiver #(
    parameter int WINDOW    = 64,
    parameter int TAU_SHIFT = 3,
    parameter int ISI_W     = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             spike_in,
    input  logic [7:0]       weight,
    output logic [7:0]       syn_current,
    output logic [ISI_W-1:0] isi,
    output logic             isi_valid,
    output logic             isi_ovf,
    output logic [7:0]       rate,
    output logic             rate_valid
);

    typedef enum logic {
        IDLE,
        MEAS
    } isi_state_t;

    localparam logic [ISI_W-1:0] CNT_MAX = '1;
    localparam logic [ISI_W-1:0] CNT_ONE = ISI_W'(1);

    logic spike_q;
    logic spike_event;

    // rst_n is active-high despite its name
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) spike_q <= 1'b0;
        else       spike_q <= spike_in;
    end

    assign spike_event = spike_in & ~spike_q;

    logic signed [9:0] cur_ext;
    logic signed [9:0] w_ext;
    logic signed [9:0] cur_sum;
    logic [7:0]        cur_d;

    always_comb begin
        cur_ext = {{2{syn_current[7]}}, syn_current};
        w_ext   = {{2{weight[7]}}, weight};
        cur_sum = cur_ext - (cur_ext >>> TAU_SHIFT) + (spike_event ? w_ext : 10'sd0);
        if (cur_sum > 10'sd127)
            cur_d = 8'h7F;
        else if (cur_sum < -10'sd128)
            cur_d = 8'h80;
        else
            cur_d = cur_sum[7:0];
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)    syn_current <= '0;
        else if (ena) syn_current <= cur_d;
    end

    isi_state_t       state_q, state_d;
    logic [ISI_W-1:0] cnt_q, cnt_d;
    logic [ISI_W-1:0] isi_d;
    logic             isi_valid_d;
    logic             isi_ovf_d;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            isi       <= '0;
            isi_valid <= 1'b0;
            isi_ovf   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            isi       <= isi_d;
            isi_valid <= isi_valid_d;
            isi_ovf   <= isi_ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        isi_d       = isi;
        isi_valid_d = 1'b0;
        isi_ovf_d   = isi_ovf;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (spike_event) begin
                        state_d = MEAS;
                        cnt_d   = CNT_ONE;
                    end
                end
                MEAS: begin
                    if (spike_event) begin
                        isi_d       = cnt_q;
                        isi_valid_d = 1'b1;
                        cnt_d       = CNT_ONE;
                        if (cnt_q == CNT_MAX) isi_ovf_d = 1'b1;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef QIF_RX_RATE_EN
    localparam int WCNT_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(WINDOW - 1);

    logic [WCNT_W-1:0] wcnt_q;
    logic [7:0]        scnt_q;
    logic [7:0]        scnt_inc;

    assign scnt_inc = (spike_event && scnt_q != 8'hFF) ? scnt_q + 8'd1 : scnt_q;

    // An event on the window-final cycle belongs to the window that is ending
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wcnt_q     <= '0;
            scnt_q     <= '0;
            rate       <= '0;
            rate_valid <= 1'b0;
        end else begin
            rate_valid <= 1'b0;
            if (ena) begin
                if (wcnt_q == WLAST) begin
                    rate       <= scnt_inc;
                    rate_valid <= 1'b1;
                    scnt_q     <= '0;
                    wcnt_q     <= '0;
                end else begin
                    wcnt_q <= wcnt_q + 1'b1;
                    scnt_q <= scnt_inc;
                end
            end
        end
    end
`else
    assign rate       = '0;
    assign rate_valid = 1'b0;
`endif

endmodule

// File: tb/tb_qif_spike_receiver.sv
// Directed self-checking bench for qif_spike_receiver (default build and QIF_RX_RATE_EN build).
module tb_qif_spike_receiver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        spike_in;
    logic [7:0]  weight;

    logic [7:0]  a_syn;
    logic [11:0] a_isi;
    logic        a_isi_valid;
    logic        a_isi_ovf;
    logic [7:0]  a_rate;
    logic        a_rate_valid;

    logic [7:0]  b_syn;
    logic [3:0]  b_isi;
    logic        b_isi_valid;
    logic        b_isi_ovf;
    logic [7:0]  b_rate;
    logic        b_rate_valid;

    int total = 0;
    int bad   = 0;

`ifdef QIF_RX_RATE_EN
    localparam bit RATE_ON = 1'b1;
`else
    localparam bit RATE_ON = 1'b0;
`endif

    qif_spike_receiver #(.WINDOW(64), .TAU_SHIFT(3), .ISI_W(12)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike_in), .weight(weight),
        .syn_current(a_syn), .isi(a_isi), .isi_valid(a_isi_valid), .isi_ovf(a_isi_ovf),
        .rate(a_rate), .rate_valid(a_rate_valid)
    );

    qif_spike_receiver #(.WINDOW(64), .TAU_SHIFT(3), .ISI_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike_in), .weight(weight),
        .syn_current(b_syn), .isi(b_isi), .isi_valid(b_isi_valid), .isi_ovf(b_isi_ovf),
        .rate(b_rate), .rate_valid(b_rate_valid)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n    = 1'b1;
        ena      = 1'b1;
        spike_in = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; ena = 1'b1; spike_in = 1'b0; weight = 8'd0;
        tick();
        total++; if (a_syn !== 8'd0)       begin bad++; $display("FAIL rst_syn got=%0h want=0", a_syn); end
        total++; if (a_isi !== 12'd0)      begin bad++; $display("FAIL rst_isi got=%0h want=0", a_isi); end
        total++; if (a_isi_valid !== 1'b0) begin bad++; $display("FAIL rst_isi_valid got=%b want=0", a_isi_valid); end
        total++; if (a_isi_ovf !== 1'b0)   begin bad++; $display("FAIL rst_isi_ovf got=%b want=0", a_isi_ovf); end
        total++; if (a_rate !== 8'd0)      begin bad++; $display("FAIL rst_rate got=%0h want=0", a_rate); end
        total++; if (a_rate_valid !== 1'b0) begin bad++; $display("FAIL rst_rate_valid got=%b want=0", a_rate_valid); end

        rst_n = 1'b0; weight = 8'd40;
        for (int e = 0; e <= 5; e++) begin
            spike_in = (e == 0 || e == 5);
            tick();
        end
        total++; if (a_isi_valid !== 1'b1 || a_isi !== 12'd5) begin
            bad++; $display("FAIL pre_rst_isi got=%b/%0d want=1/5", a_isi_valid, a_isi);
        end
        spike_in = 1'b0;
        rst_n = 1'b1;
        #1;
        total++; if (a_syn !== 8'd0 || a_isi !== 12'd0 || a_isi_valid !== 1'b0) begin
            bad++; $display("FAIL async_rst got syn=%0h isi=%0d v=%b want 0/0/0", a_syn, a_isi, a_isi_valid);
        end
        tick();
        rst_n = 1'b0;
        for (int e = 0; e <= 8; e++) begin
            spike_in = (e == 3);
            tick();
            total++; if (a_isi_valid !== 1'b0) begin
                bad++; $display("FAIL first_spike_no_valid e=%0d got=%b want=0", e, a_isi_valid);
            end
            if (e == 3) begin
                total++; if ($signed(a_syn) !== 40) begin
                    bad++; $display("FAIL post_rst_syn got=%0d want=40", $signed(a_syn));
                end
            end
        end
    endtask

    task automatic test_decay;
        int exp_d [5] = '{40, 35, 31, 28, 25};
        do_reset();
        weight = 8'd40;
        for (int i = 0; i < 5; i++) begin
            spike_in = (i == 0);
            tick();
            total++; if ($signed(a_syn) !== exp_d[i]) begin
                bad++; $display("FAIL decay[%0d] got=%0d want=%0d", i, $signed(a_syn), exp_d[i]);
            end
        end
    endtask

    task automatic test_saturation;
        int exp_p [3] = '{100, 88, 127};
        // -100 >>> 3 floors to -13, so the second value is -87
        int exp_n [3] = '{-100, -87, -128};
        do_reset();
        weight = 8'd100;
        for (int i = 0; i < 3; i++) begin
            spike_in = (i != 1);
            tick();
            total++; if ($signed(a_syn) !== exp_p[i]) begin
                bad++; $display("FAIL sat_pos[%0d] got=%0d want=%0d", i, $signed(a_syn), exp_p[i]);
            end
        end
        do_reset();
        weight = 8'h9C;
        for (int i = 0; i < 3; i++) begin
            spike_in = (i != 1);
            tick();
            total++; if ($signed(a_syn) !== exp_n[i]) begin
                bad++; $display("FAIL sat_neg[%0d] got=%0d want=%0d", i, $signed(a_syn), exp_n[i]);
            end
        end
    endtask

    task automatic test_isi;
        logic [11:0] exp_isi;
        do_reset();
        weight = 8'd1;
        exp_isi = 12'd0;
        for (int e = 0; e <= 50; e++) begin
            spike_in = (e == 10 || e == 30 || e == 45);
            tick();
            if (e == 30) exp_isi = 12'd20;
            if (e == 45) exp_isi = 12'd15;
            total++; if (a_isi_valid !== (e == 30 || e == 45)) begin
                bad++; $display("FAIL isi_valid e=%0d got=%b want=%b", e, a_isi_valid, (e == 30 || e == 45));
            end
            if (e == 10 || e == 30 || e == 40 || e == 45 || e == 50) begin
                total++; if (a_isi !== exp_isi) begin
                    bad++; $display("FAIL isi_value e=%0d got=%0d want=%0d", e, a_isi, exp_isi);
                end
            end
        end
        total++; if (a_isi_ovf !== 1'b0) begin bad++; $display("FAIL isi_ovf_a got=%b want=0", a_isi_ovf); end
    endtask

    task automatic test_isi_ovf;
        do_reset();
        for (int e = 0; e <= 50; e++) begin
            spike_in = (e == 0 || e == 20 || e == 40);
            tick();
            if (e == 19) begin
                total++; if (b_isi_ovf !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b want=0", b_isi_ovf); end
            end
            if (e == 20) begin
                total++; if (b_isi_valid !== 1'b1 || b_isi !== 4'd15 || b_isi_ovf !== 1'b1) begin
                    bad++; $display("FAIL ovf_event got v=%b isi=%0d ovf=%b want 1/15/1", b_isi_valid, b_isi, b_isi_ovf);
                end
                total++; if (a_isi !== 12'd20) begin bad++; $display("FAIL ovf_wide_isi got=%0d want=20", a_isi); end
            end
            if (e == 50) begin
                total++; if (b_isi_ovf !== 1'b1 || b_isi !== 4'd15) begin
                    bad++; $display("FAIL ovf_sticky got ovf=%b isi=%0d want 1/15", b_isi_ovf, b_isi);
                end
            end
        end
        do_reset();
        total++; if (b_isi_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", b_isi_ovf); end
    endtask

    task automatic test_rate;
        logic exp_v;
        do_reset();
        for (int e = 0; e < 200; e++) begin
            spike_in = ((e % 8) < 3);
            tick();
            exp_v = RATE_ON && ((e % 64) == 63);
            total++; if (a_rate_valid !== exp_v) begin
                bad++; $display("FAIL rate_valid e=%0d got=%b want=%b", e, a_rate_valid, exp_v);
            end
            if (e == 62 || e == 63 || e == 127 || e == 191) begin
                total++; if (a_rate !== ((RATE_ON && e != 62) ? 8'd8 : 8'd0)) begin
                    bad++; $display("FAIL rate_value e=%0d got=%0d want=%0d", e, a_rate, (RATE_ON && e != 62) ? 8 : 0);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        for (int e = 0; e <= 127; e++) begin
            spike_in = (e == 0 || e == 63);
            tick();
            if (e == 63) begin
                total++; if (a_isi_valid !== 1'b1 || a_isi !== 12'd63) begin
                    bad++; $display("FAIL b2b_isi got v=%b isi=%0d want 1/63", a_isi_valid, a_isi);
                end
                total++; if (a_rate_valid !== RATE_ON || a_rate !== (RATE_ON ? 8'd2 : 8'd0)) begin
                    bad++; $display("FAIL b2b_rate got v=%b rate=%0d want %b/%0d", a_rate_valid, a_rate, RATE_ON, RATE_ON ? 2 : 0);
                end
            end
            if (e == 127) begin
                total++; if (a_rate_valid !== RATE_ON || a_rate !== 8'd0) begin
                    bad++; $display("FAIL empty_window got v=%b rate=%0d want %b/0", a_rate_valid, a_rate, RATE_ON);
                end
            end
        end
    endtask

    task automatic test_freeze;
        int exp_run [5] = '{40, 35, 31, 28, 25};
        int exp_res [6] = '{22, 20, 18, 16, 14, 53};
        do_reset();
        weight = 8'd40;
        for (int e = 0; e <= 20; e++) begin
            ena      = !(e >= 5 && e <= 14);
            spike_in = (e == 0) || (e >= 8 && e <= 16) || (e == 20);
            tick();
            if (e <= 4) begin
                total++; if ($signed(a_syn) !== exp_run[e]) begin
                    bad++; $display("FAIL frz_run[%0d] got=%0d want=%0d", e, $signed(a_syn), exp_run[e]);
                end
            end else if (e <= 14) begin
                total++; if ($signed(a_syn) !== 25 || a_isi !== 12'd0 || a_isi_valid !== 1'b0 || a_rate_valid !== 1'b0 || a_rate !== 8'd0) begin
                    bad++; $display("FAIL frz_hold e=%0d got syn=%0d isi=%0d iv=%b rv=%b rate=%0d want 25/0/0/0/0",
                                    e, $signed(a_syn), a_isi, a_isi_valid, a_rate_valid, a_rate);
                end
            end else begin
                total++; if ($signed(a_syn) !== exp_res[e-15]) begin
                    bad++; $display("FAIL frz_resume[%0d] got=%0d want=%0d", e, $signed(a_syn), exp_res[e-15]);
                end
                total++; if (a_isi_valid !== (e == 20)) begin
                    bad++; $display("FAIL frz_valid e=%0d got=%b want=%b", e, a_isi_valid, (e == 20));
                end
            end
        end
        total++; if (a_isi !== 12'd10) begin bad++; $display("FAIL frz_isi got=%0d want=10", a_isi); end
    endtask

    initial begin
        rst_n = 1'b1; ena = 1'b1; spike_in = 1'b0; weight = 8'd0;
        test_reset();
        test_decay();
        test_saturation();
        test_isi();
        test_isi_ovf();
        test_rate();
        test_back_to_back();
        test_freeze();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
